// File: rtl/clock_period_meter_pkg.sv
// Shared types for the clock period meter: measurement FSM state encoding.
package clock_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_e;

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Brings an asynchronous level into the clk domain and flags its rising edges.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic sig_s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sig_prev_q, sig_prev_d;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], sig_in};
        sig_prev_d = sync_q[SYNC_STAGES-1];
    end

    // NOTE: flops use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            sig_prev_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            sig_prev_q <= sig_prev_d;
        end
    end

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~sig_prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles,
// reporting lock after repeated identical periods and stall when edges stop.
module clock_period_meter
    import clock_period_meter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int LOCK_COUNT  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             stalled
);

    localparam int               MW        = $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_COUNT);
    localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

    logic sig_s, rise;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .sig_in(sig_in),
        .sig_s (sig_s),
        .rise  (rise)
    );

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hcnt_q, hcnt_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             stalled_q, stalled_d;

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        match_d   = match_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        stalled_d = stalled_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ONE;
                    hcnt_d  = CNT_ONE;
                end
            end
            ST_RUN: begin
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hcnt_q;
                    valid_d  = 1'b1;
                    cnt_d    = CNT_ONE;
                    hcnt_d   = CNT_ONE;
                    // match_q==0 marks the first full period of a run; period_q is stale then
                    if (match_q != '0 && cnt_q == period_q)
                        match_d = (match_q == MATCH_MAX) ? match_q : match_q + MATCH_ONE;
                    else
                        match_d = MATCH_ONE;
                    locked_d = (match_d >= MATCH_MAX);
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = ST_STALL;
                    stalled_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = '0;
                end else begin
                    cnt_d  = cnt_q + CNT_ONE;
                    hcnt_d = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + WIDTH'(sig_s);
                end
            end
            ST_STALL: begin
                if (rise) begin
                    state_d   = ST_RUN;
                    stalled_d = 1'b0;
                    cnt_d     = CNT_ONE;
                    hcnt_d    = CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            match_q   <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            match_q   <= match_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            stalled_q <= stalled_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign stalled      = stalled_q;

endmodule
